// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module : score_pkg
// Desc   : Shared constants and types for the score binary-to-BCD converter.
// Rev    : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_BIN_W  = 14;
    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_MAX    = 9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } score_state_t;

    typedef logic [4*SCORE_DIGITS-1:0] score_bcd_t;

endpackage : score_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_adj
// Desc   : Double-dabble digit correction: add 3 to a BCD nibble that is >= 5.
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Inputs never exceed 9 here, so the 4-bit sum tops out at 12.
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/score_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module : score_bin2bcd
// Desc   : Iterative shift-and-add-3 binary-to-BCD converter with saturation;
//          the BCD output only changes when a conversion completes.
// Rev    : 1.0 - initial release
// ============================================================================
module score_bin2bcd
    import score_pkg::*;
#(
    parameter int BIN_W  = SCORE_BIN_W,
    parameter int DIGITS = SCORE_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned          c_max_val  = 10 ** DIGITS - 1;
    localparam int                   c_bcd_w    = 4 * DIGITS;
    localparam int                   c_cnt_w    = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0]     c_max_bin  = BIN_W'(c_max_val);
    localparam logic [c_cnt_w-1:0]   c_cnt_init = c_cnt_w'(BIN_W - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);

    score_state_t         r_state;
    score_state_t         w_state_nxt;

    logic [BIN_W-1:0]     r_shreg;
    logic [c_bcd_w-1:0]   r_work;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf_pend;
    logic [c_bcd_w-1:0]   r_score;
    logic                 r_ovf;
    logic                 r_done;

    logic                 w_over;
    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_work_nxt;
    logic [BIN_W-1:0]     w_shreg_nxt;
    logic                 w_unused_msb;

    assign w_over = (32'(bin) > c_max_val);

    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
        bcd_digit_adj u_adj (
            .i_digit (r_work[4*gi +: 4]),
            .o_digit (w_adj[4*gi +: 4])
        );
    end

    // The adjusted top bit is always zero for a saturated input, so it is dropped.
    assign {w_unused_msb, w_work_nxt, w_shreg_nxt} = {w_adj, r_shreg, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_score    <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shreg    <= w_over ? c_max_bin : bin;
                        r_ovf_pend <= w_over;
                        r_work     <= '0;
                        r_cnt      <= c_cnt_init;
                    end
                end
                SHIFT: begin
                    r_work  <= w_work_nxt;
                    r_shreg <= w_shreg_nxt;
                    r_cnt   <= r_cnt - c_cnt_one;
                end
                DONE: begin
                    r_score <= r_work;
                    r_ovf   <= r_ovf_pend;
                end
                default: ;
            endcase
        end
    end

    assign score_bcd = r_score;
    assign ovf       = r_ovf;
    assign done      = r_done;
    assign busy      = (r_state != IDLE);

endmodule : score_bin2bcd
`default_nettype wire

// File: tb/tb_score_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module : tb_score_bin2bcd
// Desc   : Self-checking bench for score_bin2bcd against a timing/value model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_score_bin2bcd;
    import score_pkg::*;

    localparam int c_lat = SCORE_BIN_W + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic [15:0] score_bcd;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    score_bin2bcd #(.BIN_W(SCORE_BIN_W), .DIGITS(SCORE_DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .score_bcd (score_bcd),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic score_bcd_t ref_bcd(input int v);
        int         x;
        score_bcd_t r;
        x = (v > SCORE_MAX) ? SCORE_MAX : v;
        r = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Behavioural model: a conversion is a fixed-length busy window ending in a result.
    int         m_left = 0;
    score_bcd_t m_score = '0;
    score_bcd_t m_pend = '0;
    logic       m_ovf = 1'b0;
    logic       m_pend_ovf = 1'b0;
    logic       m_done = 1'b0;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left  = 0;
            m_score = '0;
            m_ovf   = 1'b0;
            m_done  = 1'b0;
            chk_en  = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_score = m_pend;
                    m_ovf   = m_pend_ovf;
                    m_done  = 1'b1;
                end
            end else if (start) begin
                m_left     = c_lat;
                m_pend     = ref_bcd(int'(bin));
                m_pend_ovf = (int'(bin) > SCORE_MAX);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("score_bcd", 32'(score_bcd), 32'(m_score));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
        end
    end

    task automatic wait_done(output int n);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = c;
                break;
            end
        end
        if (n < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: got timeout expected done within 40 cycles");
        end
    endtask

    task automatic convert(input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
        int n;
        start = 1'b1;
        bin   = 14'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("latency", 32'(n), 32'(c_lat));
        check("result_bcd", 32'(score_bcd), 32'(exp_bcd));
        check("result_ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    int          b2b_vals [6] = '{9, 10, 99, 100, 999, 1000};
    logic [15:0] b2b_exp  [6] = '{16'h0009, 16'h0010, 16'h0099, 16'h0100, 16'h0999, 16'h1000};

    initial begin
        int n;
        int dones;

        repeat (2) @(posedge clk);
        #1;
        check("reset_bcd", 32'(score_bcd), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        convert(0, 16'h0000, 1'b0);
        convert(1234, 16'h1234, 1'b0);
        convert(9999, 16'h9999, 1'b0);
        convert(12000, 16'h9999, 1'b1);
        convert(16383, 16'h9999, 1'b1);

        // A start during SHIFT must be dropped.
        start = 1'b1;
        bin   = 14'd1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        bin   = 14'd42;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ignored_start_lat", 32'(n), 32'(c_lat - 5));
        check("ignored_start_bcd", 32'(score_bcd), 32'h1234);
        repeat (3) @(posedge clk);
        #1;
        convert(42, 16'h0042, 1'b0);

        // Reset mid-conversion aborts without a done pulse.
        start = 1'b1;
        bin   = 14'd5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd77;
        @(posedge clk);
        #1;
        check("abort_bcd", 32'(score_bcd), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'h0);

        // start held high: each done is followed by a new accept one edge later.
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bin = 14'(b2b_vals[i]);
            wait_done(n);
            check("b2b_spacing", 32'(n), 32'(c_lat + 1));
            check("b2b_bcd", 32'(score_bcd), 32'(b2b_exp[i]));
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        // Random traffic, including starts while busy and occasional resets.
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            case ($urandom_range(0, 7))
                0:       bin = 14'd9999;
                1:       bin = 14'd10000;
                2:       bin = 14'd0;
                3:       bin = 14'h3FFF;
                default: bin = 14'($urandom_range(0, 16383));
            endcase
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_score_bin2bcd
`default_nettype wire
